cpu_control_unit: RTL
=====================

Name: cpu_control_unit

Overview:
- Multi-cycle sequencer for the 32-bit cs147sec05 processor datapath.
- Runs a fixed 5-state FSM per instruction: FETCH, DECODE, EXE, MEM, WB.
- Decodes the IR contents (INSTRUCTION) and drives the 32-bit CTRL word that steers the PC, IR, register file, SP, ALU, memory-address and write-back muxes.
- Samples the datapath ZERO flag to resolve branches.

Parameters:
- CTRL_WIDTH, 32, width of CTRL word.
- ALU_OP_WIDTH, 6, width of ALU operation field CTRL[20:15].
- PC_RESET_STATE, 3'd1, encoding loaded into STATE by reset (FETCH).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, synchronous, active-high.
- INSTRUCTION  input  32  current IR contents from datapath.
- ZERO  input  1  ALU zero flag from datapath.
- CTRL  output  32  datapath control word.
- STATE  output  3  current FSM state (FETCH=1, DECODE=2, EXE=3, MEM=4, WB=5).
- ILLEGAL  output  1  unknown opcode/funct decoded for current instruction.

Behaviour:
- One clock; reset is synchronous and active-high. RST=1 at a rising CLK edge loads STATE=FETCH, clears the branch flag and clears ILLEGAL. CTRL=0 combinationally while RST=1.
- FSM: FETCH->DECODE->EXE->MEM->WB->FETCH, unconditional. Every instruction, including illegal ones, takes exactly 5 cycles. Unused encodings 0,6,7 go to FETCH on the next edge.
- CTRL bit map:
  - 0 pc_load, 1 pc_sel_1 (1=PC+1, 0=R1), 2 pc_sel_2 (1=branch target), 3 pc_sel_3 (0=jump address).
  - 4 ir_load, 5 reserved (always 0), 6 reg_r, 7 reg_w.
  - 8 r1_sel_1 (1=force R0), 9 sp_load, 10 op1_sel_1 (1=SP), 11 op2_sel_1 (1=shamt, 0=const 1), 12 op2_sel_2 (1=sign-ext imm, 0=zero-ext imm), 13 op2_sel_3 (1=op2_sel_1 path), 14 op2_sel_4 (1=R2).
  - 20:15 alu_oprn: ADD=1, SUB=2, MUL=3, SHR=4, SHL=5, AND=6, OR=7, NOR=8, SLT=9.
  - 21 ma_sel_1 (1=SP), 22 ma_sel_2 (1=PC), 23 md_sel_1, 24 mem_r, 25 mem_w.
  - 26 wd_sel_1 (1=DATA_IN), 27 wd_sel_2 (1=LUI value), 28 wd_sel_3 (1=datapath result, 0=PC+1).
  - 29 wa_sel_1 (1=rd), 30 wa_sel_2 (1=R31), 31 wa_sel_3 (1=wa_sel_1 path).
- FETCH: CTRL=0x01400000 (address=PC, mem_r).
- DECODE: CTRL=0x01400050 (FETCH bits plus ir_load and reg_r). IR captures DATA_IN at the end of DECODE.
- EXE: reg_r=1 plus operand/ALU fields per opcode. These EXE fields are held unchanged through MEM and WB. ZERO is registered into the branch flag at the end of EXE only.
- R-type opcode 0x00, funct codes: add 0x20, sub 0x22, mul 0x2c, and 0x24, or 0x25, nor 0x27, slt 0x2a, sll 0x01, srl 0x02, jr 0x08.
- I-type opcodes: addi 0x08, muli 0x1d, andi 0x0c, ori 0x0d, lui 0x0f, slti 0x0a, beq 0x04, bne 0x05, lw 0x23, sw 0x2b.
- J-type opcodes: jmp 0x02, jal 0x03, push 0x1b, pop 0x1c.
- Immediate extension: andi/ori use zero-extended imm; all other immediates are sign-extended.
- MEM:
  - lw: mem_r=1.
  - sw: mem_w=1.
  - push: M[SP]=R0, with ma_sel_1=1, r1_sel_1=1, mem_w=1.
  - pop: SP+1 computed in EXE; mem_r from SP+1.
  - All other instructions: no memory strobe.
- WB:
  - pc_load=1 on every instruction.
  - Default next PC is PC+1 (bits 1 and 3 set).
  - beq takes the branch when flag=1; bne takes it when flag=0. Taken branch sets pc_sel_2=1.
  - jmp/jal: pc_sel_3=0. jal also writes PC+1 to R31.
  - jr: pc_sel_1=0, pc_sel_2=0.
  - Register writes: R-type and I-type arithmetic/logic, lui, lw and pop assert reg_w.
  - push/pop assert sp_load.
- mem_r and mem_w are never both 1. reg_w is asserted only in WB.
- ILLEGAL: set at the end of DECODE on an unknown opcode or funct. An illegal instruction executes as a NOP (WB does PC+1 only). ILLEGAL clears at the next DECODE.

Test Plan:
- Reset: RST=1 for 2 cycles, then release -> CTRL=0 during reset, STATE=1 on the first cycle after release, CTRL=0x01400000.
- add r3,r1,r2 (INSTRUCTION=0x00221820) -> EXE CTRL=0x0000C040, WB CTRL=0xB000C0CB, back to FETCH after 5 cycles.
- beq with ZERO=1 at the end of EXE -> WB CTRL[2]=1, CTRL[0]=1. Repeat with ZERO=0 -> CTRL[2]=0, CTRL[1]=1.
- jmp 0x08000010 -> WB CTRL[0]=1, CTRL[3]=0, CTRL[7]=0; lw/sw strobes never asserted.
- sw (0xAC220004) -> MEM CTRL[25]=1, CTRL[24]=0, CTRL[7]=0 in WB. lw (0x8C220004) -> MEM CTRL[24]=1, WB CTRL[7]=1, CTRL[26]=1.
- Opcode 0x3F -> ILLEGAL=1 from EXE through WB, WB CTRL has only bits 0, 1 and 3 plus held EXE fields. Separately, RST asserted in MEM -> STATE=1 next edge.

Source files
------------

// File: rtl/cpu_control_unit.sv
// Multi-cycle sequencer for the cs147sec05 datapath.
// Steps FETCH/DECODE/EXE/MEM/WB and drives the 32-bit control word.
module cpu_control_unit #(
    parameter int         CTRL_WIDTH     = 32,
    parameter int         ALU_OP_WIDTH   = 6,
    parameter logic [2:0] PC_RESET_STATE = 3'd1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           INSTRUCTION,
    input  logic                  ZERO,
    output logic [CTRL_WIDTH-1:0] CTRL,
    output logic [2:0]            STATE,
    output logic                  ILLEGAL
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXE    = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam int B_PC_LOAD = 0;
    localparam int B_PC_SEL1 = 1;
    localparam int B_PC_SEL2 = 2;
    localparam int B_PC_SEL3 = 3;
    localparam int B_REG_R   = 6;
    localparam int B_REG_W   = 7;
    localparam int B_R1_SEL1 = 8;
    localparam int B_SP_LOAD = 9;
    localparam int B_OP1_SP  = 10;
    localparam int B_OP2_SH  = 11;
    localparam int B_OP2_SX  = 12;
    localparam int B_OP2_S3  = 13;
    localparam int B_OP2_R2  = 14;
    localparam int B_ALU_LSB = 15;
    localparam int B_MA_SEL1 = 21;
    localparam int B_MEM_R   = 24;
    localparam int B_MEM_W   = 25;
    localparam int B_WD_SEL1 = 26;
    localparam int B_WD_SEL2 = 27;
    localparam int B_WD_SEL3 = 28;
    localparam int B_WA_SEL1 = 29;
    localparam int B_WA_SEL2 = 30;
    localparam int B_WA_SEL3 = 31;

    localparam logic [CTRL_WIDTH-1:0] CTRL_FETCH  = CTRL_WIDTH'(32'h0140_0000);
    localparam logic [CTRL_WIDTH-1:0] CTRL_DECODE = CTRL_WIDTH'(32'h0140_0050);

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_MUL = ALU_OP_WIDTH'(3);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SHR = ALU_OP_WIDTH'(4);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SHL = ALU_OP_WIDTH'(5);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = ALU_OP_WIDTH'(6);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = ALU_OP_WIDTH'(7);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_NOR = ALU_OP_WIDTH'(8);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT = ALU_OP_WIDTH'(9);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_MULI  = 6'h1d;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_JMP   = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_PUSH  = 6'h1b;
    localparam logic [5:0] OP_POP   = 6'h1c;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_MUL = 6'h2c;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2a;
    localparam logic [5:0] FN_SLL = 6'h01;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;

    state_t r_state;
    logic   r_flag;
    logic   r_illegal;

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic       w_unused;

    logic [ALU_OP_WIDTH-1:0] w_alu;
    logic w_legal;
    logic w_op1_sp;
    logic w_op2_sh;
    logic w_op2_sx;
    logic w_op2_s3;
    logic w_op2_r2;
    logic w_wr_rd;
    logic w_wr_rt;
    logic w_lui;
    logic w_lw;
    logic w_sw;
    logic w_push;
    logic w_pop;
    logic w_beq;
    logic w_bne;
    logic w_jump;
    logic w_jal;
    logic w_jr;
    logic w_taken;

    logic [CTRL_WIDTH-1:0] w_exe;
    logic [CTRL_WIDTH-1:0] w_mem;
    logic [CTRL_WIDTH-1:0] w_wb;

    assign w_opcode = INSTRUCTION[31:26];
    assign w_funct  = INSTRUCTION[5:0];
    assign w_unused = ^INSTRUCTION[25:6];

    assign STATE   = r_state;
    assign ILLEGAL = r_illegal;

    // Sequencer: fixed five-step walk, branch flag and illegal flag capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= state_t'(PC_RESET_STATE);
            r_flag    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_state   <= S_DECODE;
                    r_illegal <= 1'b0;
                end
                S_DECODE: begin
                    r_state   <= S_EXE;
                    r_illegal <= ~w_legal;
                end
                S_EXE: begin
                    r_state <= S_MEM;
                    r_flag  <= ZERO;
                end
                S_MEM:   r_state <= S_WB;
                S_WB:    r_state <= S_FETCH;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Instruction decode into operand, ALU and instruction-class flags.
    always_comb begin
        w_legal  = 1'b1;
        w_alu    = '0;
        w_op1_sp = 1'b0;
        w_op2_sh = 1'b0;
        w_op2_sx = 1'b0;
        w_op2_s3 = 1'b0;
        w_op2_r2 = 1'b0;
        w_wr_rd  = 1'b0;
        w_wr_rt  = 1'b0;
        w_lui    = 1'b0;
        w_lw     = 1'b0;
        w_sw     = 1'b0;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        w_beq    = 1'b0;
        w_bne    = 1'b0;
        w_jump   = 1'b0;
        w_jal    = 1'b0;
        w_jr     = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                w_wr_rd  = 1'b1;
                w_op2_r2 = 1'b1;
                case (w_funct)
                    FN_ADD: w_alu = ALU_ADD;
                    FN_SUB: w_alu = ALU_SUB;
                    FN_MUL: w_alu = ALU_MUL;
                    FN_AND: w_alu = ALU_AND;
                    FN_OR:  w_alu = ALU_OR;
                    FN_NOR: w_alu = ALU_NOR;
                    FN_SLT: w_alu = ALU_SLT;
                    FN_SLL: begin
                        w_alu    = ALU_SHL;
                        w_op2_r2 = 1'b0;
                        w_op2_sh = 1'b1;
                        w_op2_s3 = 1'b1;
                    end
                    FN_SRL: begin
                        w_alu    = ALU_SHR;
                        w_op2_r2 = 1'b0;
                        w_op2_sh = 1'b1;
                        w_op2_s3 = 1'b1;
                    end
                    FN_JR: begin
                        w_wr_rd  = 1'b0;
                        w_op2_r2 = 1'b0;
                        w_jr     = 1'b1;
                    end
                    default: begin
                        w_legal  = 1'b0;
                        w_wr_rd  = 1'b0;
                        w_op2_r2 = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                w_alu    = ALU_ADD;
                w_op2_sx = 1'b1;
                w_wr_rt  = 1'b1;
            end
            OP_MULI: begin
                w_alu    = ALU_MUL;
                w_op2_sx = 1'b1;
                w_wr_rt  = 1'b1;
            end
            OP_ANDI: begin
                w_alu   = ALU_AND;
                w_wr_rt = 1'b1;
            end
            OP_ORI: begin
                w_alu   = ALU_OR;
                w_wr_rt = 1'b1;
            end
            OP_LUI: w_lui = 1'b1;
            OP_SLTI: begin
                w_alu    = ALU_SLT;
                w_op2_sx = 1'b1;
                w_wr_rt  = 1'b1;
            end
            OP_BEQ: begin
                w_alu    = ALU_SUB;
                w_op2_r2 = 1'b1;
                w_beq    = 1'b1;
            end
            OP_BNE: begin
                w_alu    = ALU_SUB;
                w_op2_r2 = 1'b1;
                w_bne    = 1'b1;
            end
            OP_LW: begin
                w_alu    = ALU_ADD;
                w_op2_sx = 1'b1;
                w_lw     = 1'b1;
            end
            OP_SW: begin
                w_alu    = ALU_ADD;
                w_op2_sx = 1'b1;
                w_sw     = 1'b1;
            end
            OP_JMP: w_jump = 1'b1;
            OP_JAL: begin
                w_jump = 1'b1;
                w_jal  = 1'b1;
            end
            OP_PUSH: begin
                w_alu    = ALU_SUB;
                w_op1_sp = 1'b1;
                w_op2_s3 = 1'b1;
                w_push   = 1'b1;
            end
            OP_POP: begin
                w_alu    = ALU_ADD;
                w_op1_sp = 1'b1;
                w_op2_s3 = 1'b1;
                w_pop    = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_taken = (w_beq & r_flag) | (w_bne & ~r_flag);

    // EXE fields; these stay asserted through MEM and WB.
    always_comb begin
        w_exe = '0;
        w_exe[B_REG_R]  = 1'b1;
        w_exe[B_OP1_SP] = w_op1_sp;
        w_exe[B_OP2_SH] = w_op2_sh;
        w_exe[B_OP2_SX] = w_op2_sx;
        w_exe[B_OP2_S3] = w_op2_s3;
        w_exe[B_OP2_R2] = w_op2_r2;
        w_exe[B_ALU_LSB +: ALU_OP_WIDTH] = w_alu;
    end

    // MEM adds the memory strobes; push stores R0 at the current SP.
    always_comb begin
        w_mem = w_exe;
        w_mem[B_MEM_R]   = w_lw | w_pop;
        w_mem[B_MEM_W]   = w_sw | w_push;
        w_mem[B_MA_SEL1] = w_push;
        w_mem[B_R1_SEL1] = w_push;
    end

    // WB selects next PC and the register/SP write-back path.
    always_comb begin
        w_wb = w_exe;
        w_wb[B_PC_LOAD] = 1'b1;
        w_wb[B_PC_SEL1] = ~w_jr;
        w_wb[B_PC_SEL2] = w_taken;
        w_wb[B_PC_SEL3] = ~w_jump;
        w_wb[B_REG_W]   = w_wr_rd | w_wr_rt | w_lui | w_lw | w_pop | w_jal;
        w_wb[B_SP_LOAD] = w_push | w_pop;
        w_wb[B_WD_SEL1] = w_lw | w_pop;
        w_wb[B_WD_SEL2] = w_lui;
        w_wb[B_WD_SEL3] = w_wr_rd | w_wr_rt | w_lui | w_lw | w_pop;
        w_wb[B_WA_SEL1] = w_wr_rd;
        w_wb[B_WA_SEL2] = w_jal;
        w_wb[B_WA_SEL3] = w_wr_rd | w_wr_rt | w_lui | w_lw;
    end

    // Output mux by state; reset forces an all-zero word immediately.
    always_comb begin
        CTRL = '0;
        if (!RST) begin
            case (r_state)
                S_FETCH:  CTRL = CTRL_FETCH;
                S_DECODE: CTRL = CTRL_DECODE;
                S_EXE:    CTRL = w_exe;
                S_MEM:    CTRL = w_mem;
                S_WB:     CTRL = w_wb;
                default:  CTRL = '0;
            endcase
        end
    end

endmodule
